parking_slot_manager: RTL and testbench

Parametrised successor to the single-lot parking controller. It tracks occupancy of `NUM_SLOTS` bays and allocates the lowest-numbered free bay on each arrival. Each granted bay gets a pseudo-random passcode from a free-running LFSR, and a car may leave only when it presents the passcode stored for its bay. It sits between the gate sensors/keypad front end and the display/barrier logic. Optionally, it locks a bay after repeated wrong codes.

---
 rtl/parking_pkg.sv | 66 ++++++
 rtl/parking_code_gen.sv | 35 +++
 rtl/parking_slot_manager.sv | 186 ++++++++++++++++++
 tb/tb_parking_slot_manager.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared helpers for the parking slot manager: width functions, LFSR tap masks,
// lowest-free-bay priority encoder and the exit result encoding.
package parking_pkg;

    localparam int MAX_SLOTS = 64;

    typedef enum logic [1:0] {
        EX_NONE = 2'd0,
        EX_OK   = 2'd1,
        EX_FAIL = 2'd2
    } exit_res_e;

    function automatic int slot_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Galois (right-shift) feedback masks for maximal-length sequences, bit k = tap k+1
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            default: return 32'h8020_0003;
        endcase
    endfunction

    // Index of the lowest zero bit; MAX_SLOTS when every bit is set
    function automatic logic [6:0] lowest_free(input logic [MAX_SLOTS-1:0] occ);
        logic [6:0] idx;
        idx = 7'(MAX_SLOTS);
        for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
            if (!occ[i]) idx = 7'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/parking_code_gen.sv
// Free-running Galois LFSR that supplies passcodes for newly granted bays.
module parking_code_gen
    import parking_pkg::*;
#(
    parameter int CODE_W    = 8,
    parameter int LFSR_SEED = 1
) (
    input  logic              clock,
    input  logic              gl_reset,
    input  logic              en,
    output logic [CODE_W-1:0] value
);

    localparam logic [31:0]       TAPS_ALL = lfsr_taps(CODE_W);
    localparam logic [CODE_W-1:0] TAPS     = TAPS_ALL[CODE_W-1:0];
    localparam logic [CODE_W-1:0] SEED     = CODE_W'(LFSR_SEED);

    logic [CODE_W-1:0] lfsr_q;
    logic [CODE_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clock) begin
        if (gl_reset) lfsr_q <= SEED;
        else          lfsr_q <= lfsr_d;
    end

    assign value = lfsr_q;

endmodule

// File: rtl/parking_slot_manager.sv
// Multi-bay parking controller: lowest-free-bay allocation with LFSR passcodes.
// Optional bay lockout after repeated wrong codes is compiled in with PARKING_LOCKOUT_EN.
module parking_slot_manager
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int CODE_W    = 8,
    parameter int LFSR_SEED = 1,
    parameter int MAX_FAIL  = 3,
    localparam int SLOT_W   = slot_w(NUM_SLOTS),
    localparam int CNT_W    = cnt_w(NUM_SLOTS)
) (
    input  logic                 clock,
    input  logic                 gl_reset,
    input  logic                 car_arrival,
    output logic                 can_park,
    output logic                 grant_valid,
    output logic [SLOT_W-1:0]    grant_slot,
    output logic [CODE_W-1:0]    grant_code,
    output logic                 arrival_rejected,
    input  logic                 car_exit,
    input  logic [SLOT_W-1:0]    exit_from,
    input  logic [CODE_W-1:0]    exit_code,
    output logic                 exit_ok,
    output logic                 exit_fail,
    output logic [CNT_W-1:0]     available_slots,
    output logic [NUM_SLOTS-1:0] occupied,
    output logic [NUM_SLOTS-1:0] locked
);

    logic [CODE_W-1:0]    lfsr_val;
    logic [NUM_SLOTS-1:0] occupied_q, occupied_d;
    logic [CODE_W-1:0]    code_q [NUM_SLOTS];
    logic [CODE_W-1:0]    code_d [NUM_SLOTS];
    logic [CNT_W-1:0]     avail_q, avail_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [SLOT_W-1:0]    grant_slot_q, grant_slot_d;
    logic [CODE_W-1:0]    grant_code_q, grant_code_d;
    logic                 rejected_q, rejected_d;
    logic                 exit_ok_q, exit_ok_d;
    logic                 exit_fail_q, exit_fail_d;

    logic [MAX_SLOTS-1:0] occ_ext;
    logic [6:0]           free_idx;
    logic [NUM_SLOTS-1:0] exit_sel;
    logic [NUM_SLOTS-1:0] grant_sel;
    logic [CODE_W-1:0]    stored_code;
    logic                 arrive_go, occ_hit, lock_hit, code_match, exit_go, bad_code;
    exit_res_e            ex_res;

    parking_code_gen #(
        .CODE_W    (CODE_W),
        .LFSR_SEED (LFSR_SEED)
    ) u_code_gen (
        .clock    (clock),
        .gl_reset (gl_reset),
        .en       (1'b1),
        .value    (lfsr_val)
    );

    assign can_park = (avail_q != '0);

    // Request decode against the state as it stood before this edge
    always_comb begin
        occ_ext                  = '1;
        occ_ext[NUM_SLOTS-1:0]   = occupied_q;
        free_idx                 = lowest_free(occ_ext);
        arrive_go                = car_arrival && can_park;
        stored_code              = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            exit_sel[i]  = (exit_from == SLOT_W'(i));
            grant_sel[i] = arrive_go && (free_idx == 7'(i));
            if (exit_sel[i]) stored_code = code_q[i];
        end
        occ_hit    = |(exit_sel & occupied_q);
        code_match = (exit_code == stored_code);
        exit_go    = car_exit && occ_hit && !lock_hit && code_match;
        bad_code   = car_exit && occ_hit && !lock_hit && !code_match;
        ex_res     = EX_NONE;
        if (car_exit) ex_res = exit_go ? EX_OK : EX_FAIL;
    end

    always_comb begin
        occupied_d    = occupied_q;
        code_d        = code_q;
        avail_d       = avail_q;
        grant_valid_d = arrive_go;
        grant_slot_d  = grant_slot_q;
        grant_code_d  = grant_code_q;
        rejected_d    = car_arrival && !can_park;
        exit_ok_d     = (ex_res == EX_OK);
        exit_fail_d   = (ex_res == EX_FAIL);
        if (arrive_go) begin
            grant_slot_d = SLOT_W'(free_idx);
            grant_code_d = lfsr_val;
        end
        // A bay freed this cycle was occupied before the edge, so it can never be the grant target
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (grant_sel[i]) begin
                occupied_d[i] = 1'b1;
                code_d[i]     = lfsr_val;
            end
            if (exit_go && exit_sel[i]) begin
                occupied_d[i] = 1'b0;
                code_d[i]     = '0;
            end
        end
        unique case ({arrive_go, exit_go})
            2'b10:   avail_d = avail_q - CNT_W'(1);
            2'b01:   avail_d = avail_q + CNT_W'(1);
            default: avail_d = avail_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (gl_reset) begin
            occupied_q    <= '0;
            avail_q       <= CNT_W'(NUM_SLOTS);
            grant_valid_q <= 1'b0;
            grant_slot_q  <= '0;
            grant_code_q  <= '0;
            rejected_q    <= 1'b0;
            exit_ok_q     <= 1'b0;
            exit_fail_q   <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) code_q[i] <= '0;
        end else begin
            occupied_q    <= occupied_d;
            avail_q       <= avail_d;
            grant_valid_q <= grant_valid_d;
            grant_slot_q  <= grant_slot_d;
            grant_code_q  <= grant_code_d;
            rejected_q    <= rejected_d;
            exit_ok_q     <= exit_ok_d;
            exit_fail_q   <= exit_fail_d;
            code_q        <= code_d;
        end
    end

`ifdef PARKING_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    logic [NUM_SLOTS-1:0] locked_q, locked_d;
    logic [FAIL_W-1:0]    fail_cnt_q [NUM_SLOTS];
    logic [FAIL_W-1:0]    fail_cnt_d [NUM_SLOTS];

    assign lock_hit = |(exit_sel & locked_q);
    assign locked   = locked_q;

    // Locked bays never see bad_code, so the counter stops at MAX_FAIL
    always_comb begin
        locked_d   = locked_q;
        fail_cnt_d = fail_cnt_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (exit_sel[i] && exit_go) begin
                fail_cnt_d[i] = '0;
            end else if (exit_sel[i] && bad_code) begin
                fail_cnt_d[i] = fail_cnt_q[i] + FAIL_W'(1);
                if (fail_cnt_d[i] == FAIL_W'(MAX_FAIL)) locked_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (gl_reset) begin
            locked_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) fail_cnt_q[i] <= '0;
        end else begin
            locked_q   <= locked_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end
`else
    assign lock_hit = 1'b0;
    assign locked   = '0;
`endif

    assign grant_valid      = grant_valid_q;
    assign grant_slot       = grant_slot_q;
    assign grant_code       = grant_code_q;
    assign arrival_rejected = rejected_q;
    assign exit_ok          = exit_ok_q;
    assign exit_fail        = exit_fail_q;
    assign available_slots  = avail_q;
    assign occupied         = occupied_q;

endmodule

// File: tb/tb_parking_slot_manager.sv
// Table-driven bench for parking_slot_manager (4 bays, 8-bit codes) with a queue scoreboard.
module tb_parking_slot_manager;

    localparam int NUM_SLOTS = 4;
    localparam int CODE_W    = 8;
    localparam int SLOT_W    = 2;
    localparam int CNT_W     = 3;

    logic                 clock = 1'b0;
    logic                 gl_reset;
    logic                 car_arrival;
    logic                 can_park;
    logic                 grant_valid;
    logic [SLOT_W-1:0]    grant_slot;
    logic [CODE_W-1:0]    grant_code;
    logic                 arrival_rejected;
    logic                 car_exit;
    logic [SLOT_W-1:0]    exit_from;
    logic [CODE_W-1:0]    exit_code;
    logic                 exit_ok;
    logic                 exit_fail;
    logic [CNT_W-1:0]     available_slots;
    logic [NUM_SLOTS-1:0] occupied;
    logic [NUM_SLOTS-1:0] locked;

    parking_slot_manager #(
        .NUM_SLOTS (NUM_SLOTS),
        .CODE_W    (CODE_W),
        .LFSR_SEED (1),
        .MAX_FAIL  (3)
    ) dut (
        .clock            (clock),
        .gl_reset         (gl_reset),
        .car_arrival      (car_arrival),
        .can_park         (can_park),
        .grant_valid      (grant_valid),
        .grant_slot       (grant_slot),
        .grant_code       (grant_code),
        .arrival_rejected (arrival_rejected),
        .car_exit         (car_exit),
        .exit_from        (exit_from),
        .exit_code        (exit_code),
        .exit_ok          (exit_ok),
        .exit_fail        (exit_fail),
        .available_slots  (available_slots),
        .occupied         (occupied),
        .locked           (locked)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         gv;
        logic [1:0] slot;
        logic [7:0] code;
        bit         rej;
        bit         ok;
        bit         fail;
        logic [2:0] avail;
        logic [3:0] occ;
        logic [3:0] lck;
    } exp_t;

    // cmode: 0 = stored code of the bay, 1 = stored code ^ 1, 2 = literal zero
    typedef struct {
        bit         arr;
        bit         ex;
        logic [1:0] from;
        int         cmode;
        exp_t       e;
    } vec_t;

    exp_t       sb [$];
    vec_t       tbl [$];
    logic [7:0] bay_code [NUM_SLOTS];
    logic [7:0] m_lfsr;
    int         n_cmp  = 0;
    int         n_fail = 0;

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
    endfunction

    always @(posedge clock) begin
        if (gl_reset) m_lfsr <= 8'h01;
        else          m_lfsr <= lfsr_next(m_lfsr);
    end

    function automatic exp_t mk(input bit gv, input logic [1:0] slot, input bit rej,
                                input bit ok, input bit fail, input logic [2:0] avail,
                                input logic [3:0] occ, input logic [3:0] lck);
        exp_t e;
        e.gv = gv; e.slot = slot; e.code = 8'h00; e.rej = rej; e.ok = ok;
        e.fail = fail; e.avail = avail; e.occ = occ; e.lck = lck;
        return e;
    endfunction

    function automatic vec_t mv(input bit arr, input bit ex, input logic [1:0] from,
                                input int cmode, input exp_t e);
        vec_t v;
        v.arr = arr; v.ex = ex; v.from = from; v.cmode = cmode; v.e = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic step(input bit arr, input bit ex, input logic [1:0] from,
                        input logic [7:0] code, input exp_t e_in);
        exp_t e;
        e = e_in;
        if (e.gv) begin
            e.code = m_lfsr;
            bay_code[e.slot] = m_lfsr;
        end
        if (e.ok) bay_code[from] = 8'h00;
        car_arrival = arr; car_exit = ex; exit_from = from; exit_code = code;
        sb.push_back(e);
        @(posedge clock);
        #1;
        car_arrival = 1'b0; car_exit = 1'b0;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("grant_valid", 32'(grant_valid), 32'(e.gv));
            if (e.gv) begin
                chk("grant_slot", 32'(grant_slot), 32'(e.slot));
                chk("grant_code", 32'(grant_code), 32'(e.code));
            end
            chk("arrival_rejected", 32'(arrival_rejected), 32'(e.rej));
            chk("exit_ok", 32'(exit_ok), 32'(e.ok));
            chk("exit_fail", 32'(exit_fail), 32'(e.fail));
            chk("available_slots", 32'(available_slots), 32'(e.avail));
            chk("can_park", 32'(can_park), 32'(e.avail != 3'd0));
            chk("occupied", 32'(occupied), 32'(e.occ));
            chk("locked", 32'(locked), 32'(e.lck));
        end
    endtask

    task automatic check_reset_state();
        chk("rst_available", 32'(available_slots), 32'd4);
        chk("rst_can_park", 32'(can_park), 32'd1);
        chk("rst_occupied", 32'(occupied), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_pulses", 32'({grant_valid, arrival_rejected, exit_ok, exit_fail}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] code;
        gl_reset = 1'b1; car_arrival = 1'b0; car_exit = 1'b0;
        exit_from = '0; exit_code = '0;
        for (int i = 0; i < NUM_SLOTS; i++) bay_code[i] = 8'h00;

        tbl.push_back(mv(1, 0, 0, 0, mk(1, 0, 0, 0, 0, 3'd3, 4'b0001, 4'b0)));
        tbl.push_back(mv(1, 0, 0, 0, mk(1, 1, 0, 0, 0, 3'd2, 4'b0011, 4'b0)));
        tbl.push_back(mv(1, 0, 0, 0, mk(1, 2, 0, 0, 0, 3'd1, 4'b0111, 4'b0)));
        tbl.push_back(mv(1, 0, 0, 0, mk(1, 3, 0, 0, 0, 3'd0, 4'b1111, 4'b0)));
        tbl.push_back(mv(1, 0, 0, 0, mk(0, 0, 1, 0, 0, 3'd0, 4'b1111, 4'b0)));
        tbl.push_back(mv(0, 1, 2, 0, mk(0, 0, 0, 1, 0, 3'd1, 4'b1011, 4'b0)));
        tbl.push_back(mv(1, 0, 0, 0, mk(1, 2, 0, 0, 0, 3'd0, 4'b1111, 4'b0)));
        tbl.push_back(mv(0, 1, 1, 1, mk(0, 0, 0, 0, 1, 3'd0, 4'b1111, 4'b0)));
        tbl.push_back(mv(0, 1, 2, 0, mk(0, 0, 0, 1, 0, 3'd1, 4'b1011, 4'b0)));
        tbl.push_back(mv(0, 1, 3, 0, mk(0, 0, 0, 1, 0, 3'd2, 4'b0011, 4'b0)));
        tbl.push_back(mv(0, 1, 3, 2, mk(0, 0, 0, 0, 1, 3'd2, 4'b0011, 4'b0)));
        tbl.push_back(mv(1, 0, 0, 0, mk(1, 2, 0, 0, 0, 3'd1, 4'b0111, 4'b0)));
        tbl.push_back(mv(1, 0, 0, 0, mk(1, 3, 0, 0, 0, 3'd0, 4'b1111, 4'b0)));
        tbl.push_back(mv(1, 1, 0, 0, mk(0, 0, 1, 1, 0, 3'd1, 4'b1110, 4'b0)));
        tbl.push_back(mv(1, 0, 0, 0, mk(1, 0, 0, 0, 0, 3'd0, 4'b1111, 4'b0)));
        tbl.push_back(mv(0, 1, 3, 0, mk(0, 0, 0, 1, 0, 3'd1, 4'b0111, 4'b0)));
        tbl.push_back(mv(1, 1, 1, 0, mk(1, 3, 0, 1, 0, 3'd1, 4'b1101, 4'b0)));
        tbl.push_back(mv(1, 0, 0, 0, mk(1, 1, 0, 0, 0, 3'd0, 4'b1111, 4'b0)));
        tbl.push_back(mv(0, 0, 0, 0, mk(0, 0, 0, 0, 0, 3'd0, 4'b1111, 4'b0)));

        repeat (3) @(posedge clock);
        #1;
        check_reset_state();
        chk("rst_grant_code", 32'(grant_code), 32'd0);
        chk("rst_grant_slot", 32'(grant_slot), 32'd0);
        gl_reset = 1'b0;

        foreach (tbl[k]) begin
            case (tbl[k].cmode)
                0:       code = bay_code[tbl[k].from];
                1:       code = bay_code[tbl[k].from] ^ 8'h01;
                default: code = 8'h00;
            endcase
            step(tbl[k].arr, tbl[k].ex, tbl[k].from, code, tbl[k].e);
        end

        // Reset wins over requests presented on the same edge
        gl_reset = 1'b1; car_arrival = 1'b1; car_exit = 1'b1;
        exit_from = 2'd0; exit_code = bay_code[0];
        @(posedge clock);
        #1;
        check_reset_state();
        gl_reset = 1'b0; car_arrival = 1'b0; car_exit = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) bay_code[i] = 8'h00;

        // First grant after reset carries the seed value
        step(1, 0, 0, 8'h00, mk(1, 0, 0, 0, 0, 3'd3, 4'b0001, 4'b0));
        chk("seed_code", 32'(grant_code), 32'h01);
        step(1, 0, 0, 8'h00, mk(1, 1, 0, 0, 0, 3'd2, 4'b0011, 4'b0));

`ifdef PARKING_LOCKOUT_EN
        step(0, 1, 1, bay_code[1] ^ 8'h01, mk(0, 0, 0, 0, 1, 3'd2, 4'b0011, 4'b0000));
        step(0, 1, 1, bay_code[1] ^ 8'h02, mk(0, 0, 0, 0, 1, 3'd2, 4'b0011, 4'b0000));
        step(0, 1, 1, bay_code[1] ^ 8'h04, mk(0, 0, 0, 0, 1, 3'd2, 4'b0011, 4'b0010));
        step(0, 1, 1, bay_code[1],         mk(0, 0, 0, 0, 1, 3'd2, 4'b0011, 4'b0010));
        step(0, 1, 0, bay_code[0],         mk(0, 0, 0, 1, 0, 3'd3, 4'b0010, 4'b0010));
        gl_reset = 1'b1;
        @(posedge clock);
        #1;
        check_reset_state();
        gl_reset = 1'b0;
`else
        step(0, 1, 1, bay_code[1] ^ 8'h01, mk(0, 0, 0, 0, 1, 3'd2, 4'b0011, 4'b0));
        step(0, 1, 1, bay_code[1] ^ 8'h02, mk(0, 0, 0, 0, 1, 3'd2, 4'b0011, 4'b0));
        step(0, 1, 1, bay_code[1] ^ 8'h04, mk(0, 0, 0, 0, 1, 3'd2, 4'b0011, 4'b0));
        step(0, 1, 1, bay_code[1],         mk(0, 0, 0, 1, 0, 3'd3, 4'b0001, 4'b0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
